multicycle_sequencer: RTL and testbench

- Multi-cycle control sequencer for the LEGv8-style Processor datapath.
- Consumes the decoded control word from the instruction decoder and the ALU zero flag.
- Steps each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK and drives the enables that share one ALU, the register file, and handshaked instruction and data memories.
- Counts retired instructions and flags a sticky fault on an invalid opcode class or a memory timeout.

---
 rtl/multicycle_sequencer_pkg.sv | 46 ++++
 rtl/multicycle_sequencer_mem_wait_timer.sv | 50 +++++
 rtl/multicycle_sequencer.sv | 175 +++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_sequencer_pkg.sv
`default_nettype none
`ifndef MULTICYCLE_SEQUENCER_PKG_SV
`define MULTICYCLE_SEQUENCER_PKG_SV
// ============================================================================
// Module   : multicycle_sequencer_pkg
// Brief    : Shared opcode classes, sequencer states and ALU control codes
// Revision : 1.0 - initial release
// ============================================================================
package multicycle_sequencer_pkg;

    typedef enum logic [2:0] {
        OP_RTYPE   = 3'd0,
        OP_ITYPE   = 3'd1,
        OP_LOAD    = 3'd2,
        OP_STORE   = 3'd3,
        OP_CBRANCH = 3'd4,
        OP_BTYPE   = 3'd5,
        OP_MOV     = 3'd6,
        OP_INVALID = 3'd7
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEM       = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_FAULT     = 3'd7
    } state_t;

    // ALU control codes shared with the instruction decoder
    localparam logic [3:0] c_ALU_AND    = 4'b0000;
    localparam logic [3:0] c_ALU_ORR    = 4'b0001;
    localparam logic [3:0] c_ALU_ADD    = 4'b0010;
    localparam logic [3:0] c_ALU_SUB    = 4'b0110;
    localparam logic [3:0] c_ALU_PASS_B = 4'b0111;
    localparam logic [3:0] c_ALU_NOR    = 4'b1100;

    function automatic logic is_mem_op(input op_t op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

endpackage
`endif
`default_nettype wire

// File: rtl/multicycle_sequencer_mem_wait_timer.sv
`default_nettype none
// ============================================================================
// Module   : mem_wait_timer
// Brief    : Saturating wait counter flagging when LIMIT unanswered cycles hit
// Revision : 1.0 - initial release
// ============================================================================
module mem_wait_timer #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic resetN,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_limit_reached
);

    localparam int             CW    = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [CW-1:0] c_MAX = CW'((LIMIT > 0) ? LIMIT - 1 : 0);

    logic [CW-1:0] r_count_q;
    logic [CW-1:0] w_count_d;

    always_comb begin
        w_count_d = r_count_q;
        if (i_clear) begin
            w_count_d = '0;
        end else if (i_enable && (r_count_q != c_MAX)) begin
            w_count_d = r_count_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_count_q <= '0;
        end else begin
            r_count_q <= w_count_d;
        end
    end

    // The current cycle is the LIMIT-th unanswered one when the count sits at LIMIT-1
    generate
        if (LIMIT == 0) begin : g_disabled
            assign o_limit_reached = 1'b0;
        end else begin : g_enabled
            assign o_limit_reached = (r_count_q == c_MAX);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/multicycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_sequencer
// Brief    : FETCH/DECODE/EXECUTE/MEM/WRITEBACK control FSM for LEGv8 datapath
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_sequencer
    import multicycle_sequencer_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   run,
    input  logic [2:0]             opType,
    input  logic                   regWriteFlag,
    input  logic                   zeroFlag,
    input  logic                   imemReady,
    input  logic                   dmemReady,
    output logic                   imemReq,
    output logic                   irWrite,
    output logic                   aluEnable,
    output logic                   dmemReq,
    output logic                   dmemWrite,
    output logic                   regFileWrite,
    output logic                   memToReg,
    output logic                   pcWrite,
    output logic                   pcSelBranch,
    output logic                   busy,
    output logic                   fault,
    output logic [COUNT_WIDTH-1:0] instrCount
);

    state_t                 r_state_q, w_state_d;
    op_t                    r_op_q, w_op_d;
    logic                   r_reg_write_q, w_reg_write_d;
    logic [COUNT_WIDTH-1:0] r_count_q, w_count_d;
    logic                   w_retire;
    logic                   w_timer_clear;
    logic                   w_timer_enable;
    logic                   w_limit_reached;

    always_comb begin
        w_state_d     = r_state_q;
        w_op_d        = r_op_q;
        w_reg_write_d = r_reg_write_q;
        w_count_d     = r_count_q;
        w_retire      = 1'b0;
        imemReq       = 1'b0;
        irWrite       = 1'b0;
        aluEnable     = 1'b0;
        dmemReq       = 1'b0;
        dmemWrite     = 1'b0;
        regFileWrite  = 1'b0;
        memToReg      = 1'b0;
        pcWrite       = 1'b0;
        pcSelBranch   = 1'b0;
        fault         = 1'b0;
        busy          = (r_state_q != ST_IDLE);

        case (r_state_q)
            ST_IDLE: begin
                if (run) begin
                    w_state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                imemReq = 1'b1;
                irWrite = imemReady;
                if (imemReady) begin
                    w_state_d = ST_DECODE;
                end else if (w_limit_reached) begin
                    w_state_d = ST_FAULT;
                end
            end
            ST_DECODE: begin
                w_op_d        = op_t'(opType);
                w_reg_write_d = regWriteFlag;
                w_state_d     = (op_t'(opType) == OP_INVALID) ? ST_FAULT : ST_EXECUTE;
            end
            ST_EXECUTE: begin
                aluEnable = 1'b1;
                case (r_op_q)
                    OP_LOAD, OP_STORE:         w_state_d = ST_MEM;
                    OP_RTYPE, OP_ITYPE, OP_MOV: w_state_d = ST_WRITEBACK;
                    OP_CBRANCH: begin
                        pcWrite     = 1'b1;
                        pcSelBranch = zeroFlag;
                        w_retire    = 1'b1;
                    end
                    OP_BTYPE: begin
                        pcWrite     = 1'b1;
                        pcSelBranch = 1'b1;
                        w_retire    = 1'b1;
                    end
                    default:                   w_state_d = ST_FAULT;
                endcase
            end
            ST_MEM: begin
                dmemReq   = 1'b1;
                dmemWrite = (r_op_q == OP_STORE);
                if (dmemReady) begin
                    if (r_op_q == OP_STORE) begin
                        pcWrite  = 1'b1;
                        w_retire = 1'b1;
                    end else begin
                        w_state_d = ST_WRITEBACK;
                    end
                end else if (w_limit_reached) begin
                    w_state_d = ST_FAULT;
                end
            end
            ST_WRITEBACK: begin
                regFileWrite = r_reg_write_q;
                memToReg     = (r_op_q == OP_LOAD);
                pcWrite      = 1'b1;
                w_retire     = 1'b1;
            end
            ST_FAULT: begin
                fault = 1'b1;
            end
            default: begin
                w_state_d = ST_FAULT;
            end
        endcase

        // run is only consulted at retirement, so a mid-instruction drop still completes it
        if (w_retire) begin
            w_count_d = r_count_q + COUNT_WIDTH'(1);
            w_state_d = run ? ST_FETCH : ST_IDLE;
        end
    end

    assign w_timer_clear  = (w_state_d != r_state_q) &&
                            ((w_state_d == ST_FETCH) || (w_state_d == ST_MEM));
    assign w_timer_enable = ((r_state_q == ST_FETCH) && !imemReady) ||
                            ((r_state_q == ST_MEM) && !dmemReady);

    mem_wait_timer #(
        .LIMIT (MEM_TIMEOUT)
    ) u_mem_wait_timer (
        .clk             (clk),
        .resetN          (resetN),
        .i_clear         (w_timer_clear),
        .i_enable        (w_timer_enable),
        .o_limit_reached (w_limit_reached)
    );

    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_state_q     <= ST_IDLE;
            r_op_q        <= OP_RTYPE;
            r_reg_write_q <= 1'b0;
            r_count_q     <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_op_q        <= w_op_d;
            r_reg_write_q <= w_reg_write_d;
            r_count_q     <= w_count_d;
        end
    end

    assign instrCount = r_count_q;

    // Mutual exclusion of register write and data memory request is structural
    // (WRITEBACK vs MEM), but keep an explicit guard for integration.
    always_ff @(posedge clk) begin
        if (resetN) begin
            assert (!(regFileWrite && dmemReq));
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_sequencer
// Brief    : Randomized bench with an instruction-level reference schedule
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_sequencer;

    localparam int TO = 16;
    localparam int CW = 4;
    localparam int B_IMEM = 10, B_IRW = 9, B_ALU = 8, B_DREQ = 7, B_DWR = 6;
    localparam int B_RFW = 5, B_M2R = 4, B_PCW = 3, B_PCS = 2, B_BUSY = 1, B_FAULT = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          resetN, run, regWriteFlag, zeroFlag, imemReady, dmemReady;
    logic [2:0]    opType;
    logic          imemReq, irWrite, aluEnable, dmemReq, dmemWrite, regFileWrite;
    logic          memToReg, pcWrite, pcSelBranch, busy, fault;
    logic [CW-1:0] instrCount;
    logic [10:0]   act_vec;

    multicycle_sequencer #(
        .MEM_TIMEOUT (TO),
        .COUNT_WIDTH (CW)
    ) dut (
        .clk          (clk),
        .resetN       (resetN),
        .run          (run),
        .opType       (opType),
        .regWriteFlag (regWriteFlag),
        .zeroFlag     (zeroFlag),
        .imemReady    (imemReady),
        .dmemReady    (dmemReady),
        .imemReq      (imemReq),
        .irWrite      (irWrite),
        .aluEnable    (aluEnable),
        .dmemReq      (dmemReq),
        .dmemWrite    (dmemWrite),
        .regFileWrite (regFileWrite),
        .memToReg     (memToReg),
        .pcWrite      (pcWrite),
        .pcSelBranch  (pcSelBranch),
        .busy         (busy),
        .fault        (fault),
        .instrCount   (instrCount)
    );

    assign act_vec = {imemReq, irWrite, aluEnable, dmemReq, dmemWrite, regFileWrite,
                      memToReg, pcWrite, pcSelBranch, busy, fault};

    // One record per clock cycle: inputs to drive and outputs required in that cycle
    typedef struct {
        logic          rst_n;
        logic          run;
        logic [2:0]    op;
        logic          rw, zf, ir, dr;
        logic          chk;
        logic [10:0]   exp;
        logic [CW-1:0] cnt;
    } rec_t;

    rec_t sched[$];
    rec_t cur;
    bit   cur_valid = 1'b0;
    int   cur_idx   = 0;
    int   m_count   = 0;
    bit   m_faulted = 1'b0;
    bit   m_idle    = 1'b1;
    int   last_len  = 0;
    int   errors    = 0;
    int   checks    = 0;

    function automatic rec_t blank(input bit is_busy);
        rec_t r;
        r.rst_n = 1'b1;
        r.run   = 1'($urandom);
        r.op    = 3'($urandom);
        r.rw    = 1'($urandom);
        r.zf    = 1'($urandom);
        r.ir    = 1'($urandom);
        r.dr    = 1'($urandom);
        r.chk   = 1'b1;
        r.exp   = '0;
        r.exp[B_BUSY] = is_busy;
        r.cnt   = CW'(m_count);
        return r;
    endfunction

    task automatic retire(input bit run_end);
        m_count = (m_count + 1) % (1 << CW);
        m_idle  = !run_end;
    endtask

    // Unanswered request cycles; a wait of TO or more ends in a timeout fault
    task automatic wait_phase(input bit is_mem, input bit store, input int cycles, output bit timed_out);
        rec_t r;
        for (int k = 0; k < cycles && k < TO; k++) begin
            r = blank(1'b1);
            if (is_mem) begin
                r.dr = 1'b0;
                r.exp[B_DREQ] = 1'b1;
                r.exp[B_DWR]  = store;
            end else begin
                r.ir = 1'b0;
                r.exp[B_IMEM] = 1'b1;
            end
            sched.push_back(r);
        end
        timed_out = (cycles >= TO);
        if (timed_out) m_faulted = 1'b1;
    endtask

    task automatic instr_body(input int op, input bit rw, input bit zf,
                              input int iwait, input int dwait, input bit run_end);
        rec_t r;
        bit   to;
        wait_phase(1'b0, 1'b0, iwait, to);
        if (to) return;
        r = blank(1'b1);
        r.ir = 1'b1;
        r.exp[B_IMEM] = 1'b1;
        r.exp[B_IRW]  = 1'b1;
        sched.push_back(r);
        r = blank(1'b1);
        r.op = 3'(op);
        r.rw = rw;
        sched.push_back(r);
        if (op == 7) begin
            m_faulted = 1'b1;
            return;
        end
        r = blank(1'b1);
        r.zf = zf;
        r.exp[B_ALU] = 1'b1;
        if (op == 4 || op == 5) begin
            r.exp[B_PCW] = 1'b1;
            r.exp[B_PCS] = (op == 5) | zf;
            r.run = run_end;
            sched.push_back(r);
            retire(run_end);
            return;
        end
        sched.push_back(r);
        if (op == 2 || op == 3) begin
            wait_phase(1'b1, op == 3, dwait, to);
            if (to) return;
            r = blank(1'b1);
            r.dr = 1'b1;
            r.exp[B_DREQ] = 1'b1;
            r.exp[B_DWR]  = (op == 3);
            if (op == 3) begin
                r.exp[B_PCW] = 1'b1;
                r.run = run_end;
                sched.push_back(r);
                retire(run_end);
                return;
            end
            sched.push_back(r);
        end
        r = blank(1'b1);
        r.exp[B_RFW] = rw;
        r.exp[B_M2R] = (op == 2);
        r.exp[B_PCW] = 1'b1;
        r.run = run_end;
        sched.push_back(r);
        retire(run_end);
    endtask

    task automatic add_instr(input int op, input bit rw, input bit zf,
                             input int iwait, input int dwait, input bit run_end);
        rec_t r;
        int   start;
        if (m_faulted) return;
        if (m_idle) begin
            r = blank(1'b0);
            r.run = 1'b1;
            sched.push_back(r);
            m_idle = 1'b0;
        end
        start = sched.size();
        instr_body(op, rw, zf, iwait, dwait, run_end);
        last_len = sched.size() - start;
    endtask

    task automatic add_idle(input int n);
        rec_t r;
        for (int k = 0; k < n; k++) begin
            r = blank(1'b0);
            r.run = 1'b0;
            sched.push_back(r);
        end
    endtask

    task automatic add_fault(input int n);
        rec_t r;
        for (int k = 0; k < n; k++) begin
            r = blank(1'b1);
            r.exp[B_FAULT] = 1'b1;
            sched.push_back(r);
        end
    endtask

    task automatic add_reset();
        rec_t r;
        r = blank(1'b0);
        r.rst_n = 1'b0;
        r.chk   = 1'b0;
        sched.push_back(r);
        m_count   = 0;
        m_faulted = 1'b0;
        m_idle    = 1'b1;
    endtask

    task automatic check_lit(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic int pick_wait();
        int r;
        r = $urandom_range(0, 9);
        if (r < 6) return 0;
        if (r < 8) return $urandom_range(1, 4);
        return $urandom_range(TO - 2, TO + 1);
    endfunction

    always @(negedge clk) begin
        if (cur_valid && cur.chk) begin
            checks++;
            if (act_vec !== cur.exp) begin
                errors++;
                $display("FAIL strobes cycle %0d: got %b, expected %b", cur_idx, act_vec, cur.exp);
            end
            checks++;
            if (instrCount !== cur.cnt) begin
                errors++;
                $display("FAIL instrCount cycle %0d: got %0d, expected %0d", cur_idx, instrCount, cur.cnt);
            end
        end
    end

    initial begin
        resetN = 1'b0; run = 1'b0; opType = '0; regWriteFlag = 1'b0;
        zeroFlag = 1'b0; imemReady = 1'b0; dmemReady = 1'b0;

        add_reset(); add_reset(); add_idle(2);
        add_instr(0, 1'b1, 1'($urandom), 0, 0, 1'b1);
        check_lit("rtype_len", last_len, 4);
        add_instr(2, 1'b1, 1'b0, 0, 3, 1'b1);
        check_lit("load_len", last_len, 8);
        check_lit("count_after_load", m_count, 2);
        add_instr(4, 1'b1, 1'b1, 0, 0, 1'b1);
        check_lit("cbr_taken_len", last_len, 3);
        check_lit("cbr_taken_sel", int'(sched[$].exp[B_PCS]), 1);
        add_instr(4, 1'b1, 1'b0, 0, 0, 1'b1);
        check_lit("cbr_not_taken_sel", int'(sched[$].exp[B_PCS]), 0);
        add_instr(3, 1'b0, 1'b0, 100, 0, 1'b1);
        check_lit("imem_timeout_len", last_len, TO);
        add_fault(4); add_reset(); add_idle(1);
        add_instr(0, 1'b1, 1'b0, 0, 0, 1'b1);
        add_instr(7, 1'b1, 1'b0, 0, 0, 1'b1);
        check_lit("invalid_len", last_len, 2);
        check_lit("invalid_count", m_count, 1);
        add_fault(3); add_reset();
        add_instr(6, 1'b1, 1'b0, 0, 0, 1'b1);
        add_instr(6, 1'b1, 1'b0, 0, 0, 1'b0);
        check_lit("mov_count", m_count, 2);
        add_idle(3);
        add_instr(1, 1'b1, 1'b0, TO - 1, 0, 1'b1);
        check_lit("imem_ready_wins_len", last_len, TO + 3);
        add_instr(2, 1'b1, 1'b0, 0, TO - 1, 1'b0);
        check_lit("dmem_ready_wins_len", last_len, TO + 4);
        add_idle(1);
        add_instr(2, 1'b1, 1'b0, 0, TO, 1'b1);
        add_fault(2); add_reset();
        for (int i = 0; i < 16; i++) add_instr(5, 1'b0, 1'b0, 0, 0, i != 15);
        check_lit("wrap_count", m_count, 0);
        add_idle(2);

        for (int i = 0; i < 60; i++) begin
            if (m_faulted) begin
                add_fault($urandom_range(1, 3));
                add_reset();
            end
            if (m_idle && ($urandom_range(0, 2) == 0)) add_idle($urandom_range(1, 3));
            add_instr(($urandom_range(0, 15) == 0) ? 7 : $urandom_range(0, 6),
                      1'($urandom), 1'($urandom), pick_wait(), pick_wait(),
                      $urandom_range(0, 3) != 0);
        end
        add_fault(2);

        for (int i = 0; i < sched.size(); i++) begin
            @(posedge clk);
            #1;
            cur          = sched[i];
            cur_idx      = i;
            resetN       = cur.rst_n;
            run          = cur.run;
            opType       = cur.op;
            regWriteFlag = cur.rw;
            zeroFlag     = cur.zf;
            imemReady    = cur.ir;
            dmemReady    = cur.dr;
            cur_valid    = 1'b1;
        end
        @(posedge clk);
        #1;
        cur_valid = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
